// File: rtl/axi_wr_rd_checker_pkg.sv
// Shared types for the AXI write/read-back checker: state encoding, AXI channel structs, data pattern.
// Default widths here match the checker's default parameters.
package axi_wr_rd_checker_pkg;

    localparam int unsigned DefAddrWidth = 64;
    localparam int unsigned DefDataWidth = 128;
    localparam int unsigned DefIdWidth   = 6;
    localparam int unsigned DefUserWidth = 2;
    localparam int unsigned LanesPerBeat = DefDataWidth / 32;

    localparam logic [1:0] RespOkay  = 2'b00;
    localparam logic [1:0] BurstIncr = 2'b01;

    typedef logic [DefDataWidth-1:0]   data_t;
    typedef logic [DefDataWidth/8-1:0] strb_t;
    typedef logic [DefAddrWidth-1:0]   addr_t;
    typedef logic [DefIdWidth-1:0]     id_t;
    typedef logic [DefUserWidth-1:0]   user_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AW   = 3'd1,
        W    = 3'd2,
        B    = 3'd3,
        AR   = 3'd4,
        R    = 3'd5,
        DONE = 3'd6
    } state_e;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
        logic [5:0] atop;
        user_t      user;
    } aw_chan_t;

    typedef struct packed {
        data_t data;
        strb_t strb;
        logic  last;
        user_t user;
    } w_chan_t;

    typedef struct packed {
        id_t        id;
        logic [1:0] resp;
        user_t      user;
    } b_chan_t;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
        user_t      user;
    } ar_chan_t;

    typedef struct packed {
        id_t        id;
        data_t      data;
        logic [1:0] resp;
        logic       last;
        user_t      user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     ar_ready;
        logic     w_ready;
        logic     b_valid;
        b_chan_t  b;
        logic     r_valid;
        r_chan_t  r;
    } resp_t;

    // Lane k of beat idx carries seed + idx*LanesPerBeat + k, wrapping mod 2^32.
    function automatic data_t pattern_beat(input logic [31:0] seed, input logic [8:0] idx);
        data_t d;
        d = '0;
        for (int k = 0; k < int'(LanesPerBeat); k++) begin
            d[k*32 +: 32] = seed + 32'(idx) * 32'(LanesPerBeat) + 32'(k);
        end
        return d;
    endfunction

endpackage

// File: rtl/axi_wr_rd_checker.sv
// AXI4 master: writes one INCR burst of patterned data, waits for B, reads it back and checks every R beat.
// Latency: one AXI round trip per phase, no bubbles between W beats; all channels honour valid/ready backpressure.
// Payloads come from registers and stay stable while valid is high; only reset may drop a valid mid-handshake.
module axi_wr_rd_checker
    import axi_wr_rd_checker_pkg::*;
#(
    parameter int unsigned AddrWidth  = DefAddrWidth,
    parameter int unsigned DataWidth  = DefDataWidth,
    parameter int unsigned IdWidth    = DefIdWidth,
    parameter int unsigned UserWidth  = DefUserWidth,
    parameter int unsigned AxiId      = 0,
    parameter type         axi_req_t  = req_t,
    parameter type         axi_resp_t = resp_t
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [7:0]           len_i,
    input  logic [31:0]          seed_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic [8:0]           mismatch_cnt_o,
    output axi_req_t             axi_req_o,
    input  axi_resp_t            axi_rsp_i
);

    localparam int unsigned AddrLsb = $clog2(DataWidth / 8);

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] addr_q;
    logic [7:0]           len_q;
    logic [31:0]          seed_q;
    logic [8:0]           beat_q;
    logic                 error_q;
    logic [8:0]           mis_q;

    logic  last_beat;
    logic  w_hs;
    logic  r_hs;
    data_t pat_dat;

    assign last_beat = (beat_q == {1'b0, len_q});
    assign w_hs      = (state_q == W) && axi_rsp_i.w_ready;
    assign r_hs      = (state_q == R) && axi_rsp_i.r_valid;
    // One pattern generator serves both the W stream and the R comparison.
    assign pat_dat   = pattern_beat(seed_q, beat_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_i)                 state_d = AW;
            AW:   if (axi_rsp_i.aw_ready)      state_d = W;
            W:    if (w_hs && last_beat)       state_d = B;
            B:    if (axi_rsp_i.b_valid)       state_d = AR;
            AR:   if (axi_rsp_i.ar_ready)      state_d = R;
            R:    if (r_hs && (axi_rsp_i.r.last || last_beat)) state_d = DONE;
            DONE:                              state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    always_comb begin
        axi_req_o = '0;

        axi_req_o.aw.id    = IdWidth'(AxiId);
        axi_req_o.aw.addr  = addr_q;
        axi_req_o.aw.len   = len_q;
        axi_req_o.aw.size  = 3'(AddrLsb);
        axi_req_o.aw.burst = BurstIncr;
        axi_req_o.aw.user  = UserWidth'(0);
        axi_req_o.aw_valid = (state_q == AW);

        axi_req_o.w.data   = pat_dat;
        axi_req_o.w.strb   = '1;
        axi_req_o.w.last   = last_beat;
        axi_req_o.w.user   = UserWidth'(0);
        axi_req_o.w_valid  = (state_q == W);

        axi_req_o.b_ready  = (state_q == B);

        axi_req_o.ar.id    = IdWidth'(AxiId);
        axi_req_o.ar.addr  = addr_q;
        axi_req_o.ar.len   = len_q;
        axi_req_o.ar.size  = 3'(AddrLsb);
        axi_req_o.ar.burst = BurstIncr;
        axi_req_o.ar.user  = UserWidth'(0);
        axi_req_o.ar_valid = (state_q == AR);

        axi_req_o.r_ready  = (state_q == R);

        busy_o         = (state_q != IDLE);
        done_o         = (state_q == DONE);
        error_o        = error_q;
        mismatch_cnt_o = mis_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            len_q   <= '0;
            seed_q  <= '0;
            beat_q  <= '0;
            error_q <= 1'b0;
            mis_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        addr_q  <= {addr_i[AddrWidth-1:AddrLsb], AddrLsb'(0)};
                        len_q   <= len_i;
                        seed_q  <= seed_i;
                        beat_q  <= '0;
                        error_q <= 1'b0;
                        mis_q   <= '0;
                    end
                end
                W: begin
                    // Rewind on the last beat so the read phase starts counting from zero.
                    if (w_hs) beat_q <= last_beat ? 9'd0 : beat_q + 9'd1;
                end
                B: begin
                    if (axi_rsp_i.b_valid &&
                        (axi_rsp_i.b.resp != RespOkay || axi_rsp_i.b.id != IdWidth'(AxiId))) begin
                        error_q <= 1'b1;
                    end
                end
                R: begin
                    if (r_hs) begin
                        beat_q <= beat_q + 9'd1;
                        if (axi_rsp_i.r.data != pat_dat) begin
                            error_q <= 1'b1;
                            if (mis_q != 9'd511) mis_q <= mis_q + 9'd1;
                        end
                        if (axi_rsp_i.r.resp != RespOkay || axi_rsp_i.r.last != last_beat) begin
                            error_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    logic unused_rsp;
    assign unused_rsp = ^{axi_rsp_i.r.id, axi_rsp_i.r.user, axi_rsp_i.b.user};

endmodule

// File: tb/tb_axi_wr_rd_checker.sv
// Randomized bench: a behavioural AXI memory slave with random stalls, and a scoreboard of expected run results.
module tb_axi_wr_rd_checker;

    typedef axi_wr_rd_checker_pkg::req_t  req_t;
    typedef axi_wr_rd_checker_pkg::resp_t resp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] addr = '0;
    logic [7:0]  len = '0;
    logic [31:0] seed = '0;
    logic        busy, done, error;
    logic [8:0]  mis;
    req_t        req;
    resp_t       rsp = '0;

    always #5 clk = ~clk;

    axi_wr_rd_checker #(.AxiId(0)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .addr_i(addr), .len_i(len),
        .seed_i(seed), .busy_o(busy), .done_o(done), .error_o(error),
        .mismatch_cnt_o(mis), .axi_req_o(req), .axi_rsp_i(rsp)
    );

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
        logic [31:0] seed;
        bit          err;
        int          mis;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    int          w_cnt = 0;
    int          dmax = 0;
    logic [1:0]  bresp_cfg = 2'b00;
    bit          corrupt_cfg = 0;
    logic [31:0] lane0_log[$];
    logic [127:0] mem [logic [63:0]];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference pattern: lane k of beat i holds seed + 4*i + k (128-bit bus, four lanes).
    function automatic logic [127:0] exp_beat(input logic [31:0] s, input int i);
        logic [127:0] v;
        for (int k = 0; k < 4; k++) v[32*k +: 32] = s + 32'(4*i + k);
        return v;
    endfunction

    function automatic int rnd();
        return (dmax == 0) ? 0 : int'($urandom_range(0, dmax));
    endfunction

    // Memory slave, evaluated on the falling edge; handshakes decided here complete on the next rising edge.
    initial begin
        bit          aw_pend, w_pend, ar_pend, b_pend, r_pend, b_todo;
        bit          aw_hold, w_hold, ar_hold;
        int          aw_dly, w_dly, ar_dly, b_dly, r_dly, wr_beat, rd_beat, rd_left;
        logic [63:0] wr_addr, rd_addr;
        axi_wr_rd_checker_pkg::aw_chan_t aw_prev;
        axi_wr_rd_checker_pkg::w_chan_t  w_prev;
        axi_wr_rd_checker_pkg::ar_chan_t ar_prev;
        aw_pend = 0; w_pend = 0; ar_pend = 0; b_pend = 0; r_pend = 0; b_todo = 0;
        aw_hold = 0; w_hold = 0; ar_hold = 0;
        aw_dly = 0; w_dly = 0; ar_dly = 0; b_dly = 0; r_dly = 0;
        wr_beat = 0; rd_beat = 0; rd_left = 0; wr_addr = '0; rd_addr = '0;
        aw_prev = '0; w_prev = '0; ar_prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rsp = '0;
                aw_pend = 0; w_pend = 0; ar_pend = 0; b_pend = 0; r_pend = 0; b_todo = 0;
                aw_hold = 0; w_hold = 0; ar_hold = 0; rd_left = 0;
                aw_dly = rnd(); w_dly = rnd(); ar_dly = rnd(); r_dly = rnd();
                continue;
            end
            // AW
            if (aw_pend) begin rsp.aw_ready = 0; aw_pend = 0; aw_dly = rnd(); end
            if (req.aw_valid && aw_hold) chk("aw_stable", 128'(req.aw), 128'(aw_prev));
            if (req.aw_valid && !rsp.aw_ready) begin
                if (aw_dly == 0) rsp.aw_ready = 1; else aw_dly--;
            end
            if (req.aw_valid && rsp.aw_ready) begin
                aw_pend = 1; aw_hold = 0; wr_addr = req.aw.addr; wr_beat = 0;
                if (exp_q.size() == 0) chk("aw_unexpected", 1, 0);
                else begin
                    chk("aw_addr", req.aw.addr, exp_q[0].addr);
                    chk("aw_len", req.aw.len, exp_q[0].len);
                    chk("aw_size_burst", {req.aw.size, req.aw.burst}, {3'd4, 2'b01});
                end
            end else aw_hold = req.aw_valid;
            aw_prev = req.aw;
            // W
            if (w_pend) begin rsp.w_ready = 0; w_pend = 0; w_dly = rnd(); end
            if (req.w_valid && w_hold) chk("w_stable", 128'(req.w.data), 128'(w_prev.data));
            if (req.w_valid && !rsp.w_ready) begin
                if (w_dly == 0) rsp.w_ready = 1; else w_dly--;
            end
            if (req.w_valid && rsp.w_ready) begin
                w_pend = 1; w_hold = 0;
                mem[(wr_addr >> 4) + 64'(wr_beat)] = req.w.data;
                lane0_log.push_back(req.w.data[31:0]);
                if (exp_q.size() != 0) begin
                    chk("w_data", req.w.data, exp_beat(exp_q[0].seed, wr_beat));
                    chk("w_last", req.w.last, (wr_beat == int'(exp_q[0].len)));
                    chk("w_strb", req.w.strb, 16'hFFFF);
                end
                if (req.w.last) begin b_todo = 1; b_dly = rnd(); end
                wr_beat++; w_cnt++;
            end else w_hold = req.w_valid;
            w_prev = req.w;
            // B
            if (b_pend) begin
                rsp.b_valid = 0; b_pend = 0;
                if (corrupt_cfg) mem[(wr_addr >> 4) + 64'd2] = mem[(wr_addr >> 4) + 64'd2] ^ 128'h1;
            end
            if (b_todo && !rsp.b_valid) begin
                if (b_dly == 0) begin
                    rsp.b_valid = 1; rsp.b.resp = bresp_cfg; rsp.b.id = '0; b_todo = 0;
                end else b_dly--;
            end
            if (rsp.b_valid && req.b_ready) b_pend = 1;
            // AR
            if (ar_pend) begin rsp.ar_ready = 0; ar_pend = 0; ar_dly = rnd(); end
            if (req.ar_valid && ar_hold) chk("ar_stable", 128'(req.ar), 128'(ar_prev));
            if (req.ar_valid && !rsp.ar_ready) begin
                if (ar_dly == 0) rsp.ar_ready = 1; else ar_dly--;
            end
            if (req.ar_valid && rsp.ar_ready) begin
                ar_pend = 1; ar_hold = 0;
                rd_addr = req.ar.addr; rd_beat = 0; rd_left = int'(req.ar.len) + 1; r_dly = rnd();
                if (exp_q.size() != 0) begin
                    chk("ar_addr", req.ar.addr, exp_q[0].addr);
                    chk("ar_len", req.ar.len, exp_q[0].len);
                end
            end else ar_hold = req.ar_valid;
            ar_prev = req.ar;
            // R
            if (r_pend) begin rsp.r_valid = 0; r_pend = 0; end
            if (rd_left > 0 && !rsp.r_valid) begin
                if (r_dly == 0) begin
                    logic [63:0] key;
                    key = (rd_addr >> 4) + 64'(rd_beat);
                    rsp.r_valid = 1;
                    rsp.r.data = mem.exists(key) ? mem[key] : '0;
                    rsp.r.last = (rd_left == 1);
                    rsp.r.resp = 2'b00;
                    rsp.r.id = '0;
                end else r_dly--;
            end
            if (rsp.r_valid && req.r_ready) begin
                r_pend = 1; rd_beat++; rd_left--; r_dly = rnd();
            end
        end
    end

    // Scoreboard monitor: pops the expected outcome whenever the DUT signals completion.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (exp_q.size() == 0) chk("done_unexpected", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("done_error", error, e.err);
                    chk("done_mismatch", mis, e.mis);
                end
                done_cnt++;
                @(negedge clk);
                chk("done_pulse_width", {done, busy}, 2'b00);
            end
        end
    end

    task automatic run(input logic [63:0] a, input logic [7:0] l, input logic [31:0] s,
                       input bit corrupt, input logic [1:0] br);
        exp_t e;
        int   d0;
        e.addr = a & ~64'hF; e.len = l; e.seed = s;
        e.err = corrupt || (br != 2'b00); e.mis = corrupt ? 1 : 0;
        exp_q.push_back(e);
        corrupt_cfg = corrupt; bresp_cfg = br; d0 = done_cnt;
        @(negedge clk);
        start = 1; addr = a; len = l; seed = s;
        @(negedge clk);
        start = 0; addr = {$urandom, $urandom}; len = 8'($urandom); seed = $urandom;
        // A start while busy must be ignored.
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        for (int c = 0; c < 6000 && done_cnt == d0; c++) @(negedge clk);
        if (done_cnt == d0) begin
            chk("run_timeout", 0, 1);
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valids", {req.aw_valid, req.w_valid, req.ar_valid, req.b_ready, req.r_ready}, 0);
        chk("rst_status", {busy, done, error}, 0);
        chk("rst_mismatch", mis, 0);
        rst_n = 1;
        repeat (2) @(negedge clk);

        lane0_log.delete();
        run(64'h1000, 8'd3, 32'hA5A5_0000, 0, 2'b00);
        chk("s1_beats", lane0_log.size(), 4);
        if (lane0_log.size() >= 2) begin
            chk("s1_beat0_lane0", lane0_log[0], 32'hA5A5_0000);
            chk("s1_beat1_lane0", lane0_log[1], 32'hA5A5_0004);
        end

        lane0_log.delete();
        run(64'h2008, 8'd0, $urandom, 0, 2'b00);
        chk("s2_beats", lane0_log.size(), 1);

        dmax = 5;
        run(64'h1000, 8'd3, 32'hA5A5_0000, 0, 2'b00);
        for (int i = 0; i < 4; i++) begin
            run({48'h0, 16'($urandom)}, 8'($urandom_range(0, 15)), $urandom, 0, 2'b00);
        end
        run(64'h3000, 8'd3, $urandom, 1, 2'b00);
        run(64'h4000, 8'd3, $urandom, 0, 2'b10);
        run(64'h5000, 8'd2, 32'hFFFF_FFF0, 0, 2'b00);

        // Abort in the middle of the write burst.
        dmax = 0;
        exp_q.push_back('{64'h6000, 8'd3, 32'h1234_5678, 0, 0});
        w_cnt = 0;
        @(negedge clk); start = 1; addr = 64'h6000; len = 8'd3; seed = 32'h1234_5678;
        @(negedge clk); start = 0;
        for (int c = 0; c < 200 && w_cnt < 2; c++) @(negedge clk);
        chk("s6_reached_w", w_cnt >= 2, 1);
        rst_n = 0;
        #1;
        chk("s6_valids", {req.aw_valid, req.w_valid, req.ar_valid, req.b_ready, req.r_ready}, 0);
        chk("s6_busy", busy, 0);
        exp_q.delete();
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);

        lane0_log.delete();
        run(64'h8000, 8'd255, $urandom, 0, 2'b00);
        chk("s6_len255_beats", lane0_log.size(), 256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
